// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the round-robin boot ROM arbiter.
//   state_e        : arbiter FSM states
//   ROM_ARB_CNT_W  : width of each per-requester grant counter
//   ROM_ARB_DATA_W : ROM word width
//   NREQ_MIN/MAX   : legal range of the requester count
package rom_arb_pkg;

  localparam int unsigned ROM_ARB_CNT_W  = 32;
  localparam int unsigned ROM_ARB_DATA_W = 32;
  localparam int unsigned NREQ_MIN       = 2;
  localparam int unsigned NREQ_MAX       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage : rom_arb_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   valid   : request vector
//   ptr     : index of the last requester served (lowest priority)
//   grant_c : one-hot grant, first valid after ptr with wrap-around
//   idx_c   : index of the granted requester
//   any_c   : at least one request is valid
module rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_c,
  output logic [IW-1:0] idx_c,
  output logic          any_c
);

  int unsigned k;

  // Scan ptr+1 .. ptr+N (mod N); the first hit wins.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    k       = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      k = (32'(ptr) + i) % N;
      if (!any_c && valid[IW'(k)]) begin
        any_c            = 1'b1;
        idx_c            = IW'(k);
        grant_c[IW'(k)]  = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/rom_rr_arbiter.sv
// Shares one synchronous ROM (1-cycle registered read) between NREQ requesters
// with round-robin grant and valid/ready handshakes on request and response.
// Optional macro ROM_ARB_STAT_EN builds 32-bit per-requester grant counters;
// without it o_stat_cnt is tied to zero.
// Ports:
//   i_clk, i_nrst       : clock, asynchronous active-low reset
//   i_req_valid/addr    : per-requester request (addr slice [k*abits +: abits])
//   o_req_ready         : request accepted, one-hot or zero (same-cycle)
//   o_resp_valid        : response valid, owner's bit only
//   i_resp_ready        : response accepted per requester
//   o_resp_data         : response data, shared
//   o_rom_addr/i_rom_data : ROM address (registered) and read data
//   o_stat_cnt          : per-requester grant counters
module rom_rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned abits = 12,
  parameter int unsigned NREQ  = 3
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic [NREQ-1:0]               i_req_valid,
  input  logic [NREQ*abits-1:0]         i_req_addr,
  output logic [NREQ-1:0]               o_req_ready,
  output logic [NREQ-1:0]               o_resp_valid,
  input  logic [NREQ-1:0]               i_resp_ready,
  output logic [ROM_ARB_DATA_W-1:0]     o_resp_data,
  output logic [abits-1:0]              o_rom_addr,
  input  logic [ROM_ARB_DATA_W-1:0]     i_rom_data,
  output logic [NREQ*ROM_ARB_CNT_W-1:0] o_stat_cnt
);

  localparam int unsigned IW = $clog2(NREQ);

  if ((NREQ < NREQ_MIN) || (NREQ > NREQ_MAX)) begin : g_bad_nreq
    $error("rom_rr_arbiter: NREQ out of range");
  end

  state_e          state_q, state_d;
  logic [abits-1:0] r_addr;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_ptr;
  logic [NREQ-1:0] r_resp_valid;

  logic [NREQ-1:0] pick_grant_c;
  logic [IW-1:0]   pick_idx_c;
  logic            pick_any_c;
  logic            owner_ack_c;
  logic            arb_en_c;
  logic            take_c;
  logic [NREQ-1:0] grant_c;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .valid   (i_req_valid),
    .ptr     (r_ptr),
    .grant_c (pick_grant_c),
    .idx_c   (pick_idx_c),
    .any_c   (pick_any_c)
  );

  // Arbitration is open in IDLE, or in RESP on the cycle the owner accepts.
  always_comb begin
    owner_ack_c = (state_q == RESP) && i_resp_ready[r_owner];
    arb_en_c    = (state_q == IDLE) || owner_ack_c;
    take_c      = arb_en_c && pick_any_c;
    grant_c     = take_c ? pick_grant_c : '0;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take_c) state_d = WAIT;
      WAIT:    state_d = RESP;
      RESP:    if (owner_ack_c) state_d = take_c ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Address/owner/pointer latch on grant; response valid registered per owner.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_addr       <= '0;
      r_owner      <= '0;
      r_ptr        <= IW'(NREQ - 1);
      r_resp_valid <= '0;
    end else begin
      if (take_c) begin
        r_addr  <= i_req_addr[pick_idx_c*abits +: abits];
        r_owner <= pick_idx_c;
        r_ptr   <= pick_idx_c;
      end
      r_resp_valid <= (state_d == RESP) ? (NREQ'(1) << r_owner) : '0;
    end
  end

  // Ready is gated by reset so nothing is accepted while reset is asserted.
  assign o_req_ready  = grant_c & {NREQ{i_nrst}};
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = (state_q == RESP) ? i_rom_data : '0;
  assign o_rom_addr   = r_addr;

`ifdef ROM_ARB_STAT_EN
  logic [ROM_ARB_CNT_W-1:0] r_cnt [NREQ];

  // Grant counters, free-running with natural wrap.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int unsigned k = 0; k < NREQ; k++) r_cnt[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (grant_c[k]) r_cnt[k] <= r_cnt[k] + ROM_ARB_CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign o_stat_cnt[g*ROM_ARB_CNT_W +: ROM_ARB_CNT_W] = r_cnt[g];
  end
`else
  assign o_stat_cnt = '0;
`endif

endmodule : rom_rr_arbiter

// File: tb/tb_rom_rr_arbiter.sv
// Self-checking bench for rom_rr_arbiter (abits=12, NREQ=3) with a behavioural ROM.
module tb_rom_rr_arbiter;

  localparam int unsigned AB = 12;
  localparam int unsigned NR = 3;

  logic          i_clk;
  logic          i_nrst;
  logic [NR-1:0] req_valid;
  logic [NR*AB-1:0] req_addr;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] resp_valid;
  logic [NR-1:0] resp_ready;
  logic [31:0]   resp_data;
  logic [AB-1:0] rom_addr;
  logic [31:0]   rom_q;
  logic [NR*32-1:0] stat_cnt;

  int total = 0;
  int bad   = 0;

  rom_rr_arbiter #(.abits(AB), .NREQ(NR)) dut (
    .i_clk        (i_clk),
    .i_nrst       (i_nrst),
    .i_req_valid  (req_valid),
    .i_req_addr   (req_addr),
    .o_req_ready  (req_ready),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_data  (resp_data),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_q),
    .o_stat_cnt   (stat_cnt)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] rom_f(input logic [AB-1:0] a);
    return {4'hA, a, ~a[7:0], a[11:4]};
  endfunction

  // Synchronous ROM: address sampled every rising edge.
  always @(posedge i_clk) rom_q <= rom_f(rom_addr);

  // Round-robin rule: first valid requester after the last one served.
  function automatic int next_owner(input logic [NR-1:0] v, input int last);
    for (int i = 1; i <= int'(NR); i++) begin
      if (v[(last + i) % int'(NR)]) return (last + i) % int'(NR);
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] oh(input int k);
    logic [NR-1:0] v;
    v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_addr(input int k, input logic [AB-1:0] a);
    req_addr[k*AB +: AB] = a;
  endtask

  task automatic do_reset();
    i_nrst = 1'b0;
    req_valid = '0;
    resp_ready = '0;
    req_addr = '0;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_nrst = 1'b1;
  endtask

  task automatic serve(input int k);
    req_valid = oh(k);
    resp_ready = '1;
    step();
    req_valid = '0;
    step();
    step();
  endtask

  task automatic test_reset();
    i_nrst = 1'b0;
    req_valid = '1;
    resp_ready = '1;
    #2;
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    total++; if (resp_valid !== 3'b000) begin bad++; $display("FAIL reset_resp_valid got=%b exp=000", resp_valid); end
    total++; if (rom_addr !== 12'h000) begin bad++; $display("FAIL reset_rom_addr got=%h exp=000", rom_addr); end
    total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL reset_resp_data got=%h exp=0", resp_data); end
    total++; if (stat_cnt !== '0) begin bad++; $display("FAIL reset_stat got=%h exp=0", stat_cnt); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    set_addr(0, 12'h010);
    req_valid = 3'b001;
    @(negedge i_clk);
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL single_grant got=%b exp=001", req_ready); end
    step();
    req_valid = '0;
    @(negedge i_clk);
    total++; if (rom_addr !== 12'h010) begin bad++; $display("FAIL single_rom_addr got=%h exp=010", rom_addr); end
    total++; if (resp_valid !== 3'b000) begin bad++; $display("FAIL single_wait_valid got=%b exp=000", resp_valid); end
    step();
    resp_ready = 3'b001;
    @(negedge i_clk);
    total++; if (resp_valid !== 3'b001) begin bad++; $display("FAIL single_resp_valid got=%b exp=001", resp_valid); end
    total++; if (resp_data !== rom_f(12'h010)) begin bad++; $display("FAIL single_resp_data got=%h exp=%h", resp_data, rom_f(12'h010)); end
    step();
    @(negedge i_clk);
    total++; if (resp_valid !== 3'b000) begin bad++; $display("FAIL single_done got=%b exp=000", resp_valid); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [AB-1:0] a [NR];
    do_reset();
    for (int k = 0; k < int'(NR); k++) begin
      a[k] = AB'($urandom);
      set_addr(k, a[k]);
    end
    req_valid = '1;
    resp_ready = '1;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      total++; if (req_ready !== oh(k % 3)) begin bad++; $display("FAIL b2b_grant k=%0d got=%b exp=%b", k, req_ready, oh(k % 3)); end
      if (k > 0) begin
        total++; if (resp_valid !== oh((k - 1) % 3)) begin bad++; $display("FAIL b2b_resp_valid k=%0d got=%b exp=%b", k, resp_valid, oh((k - 1) % 3)); end
        total++; if (resp_data !== rom_f(a[(k - 1) % 3])) begin bad++; $display("FAIL b2b_resp_data k=%0d got=%h exp=%h", k, resp_data, rom_f(a[(k - 1) % 3])); end
      end
      step();
      @(negedge i_clk);
      total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL b2b_wait_ready k=%0d got=%b exp=000", k, req_ready); end
      total++; if (rom_addr !== a[k % 3]) begin bad++; $display("FAIL b2b_rom_addr k=%0d got=%h exp=%h", k, rom_addr, a[k % 3]); end
      step();
    end
    req_valid = '0;
    @(negedge i_clk);
    total++; if (resp_valid !== 3'b100) begin bad++; $display("FAIL b2b_last_valid got=%b exp=100", resp_valid); end
    total++; if (resp_data !== rom_f(a[2])) begin bad++; $display("FAIL b2b_last_data got=%h exp=%h", resp_data, rom_f(a[2])); end
    step();
  endtask

  task automatic test_stall();
    logic [AB-1:0] a0, a1;
    do_reset();
    a0 = AB'($urandom);
    a1 = AB'($urandom);
    set_addr(0, a0);
    set_addr(1, a1);
    set_addr(2, AB'($urandom));
    req_valid = 3'b001;
    @(negedge i_clk);
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL stall_grant got=%b exp=001", req_ready); end
    step();
    req_valid = 3'b110;
    resp_ready = 3'b110;
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      total++; if (resp_valid !== 3'b001) begin bad++; $display("FAIL stall_valid c=%0d got=%b exp=001", c, resp_valid); end
      total++; if (resp_data !== rom_f(a0)) begin bad++; $display("FAIL stall_data c=%0d got=%h exp=%h", c, resp_data, rom_f(a0)); end
      total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL stall_ready c=%0d got=%b exp=000", c, req_ready); end
      total++; if (rom_addr !== a0) begin bad++; $display("FAIL stall_rom_addr c=%0d got=%h exp=%h", c, rom_addr, a0); end
      step();
    end
    resp_ready = 3'b001;
    @(negedge i_clk);
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL stall_handoff got=%b exp=010", req_ready); end
    total++; if (resp_valid !== 3'b001) begin bad++; $display("FAIL stall_final_valid got=%b exp=001", resp_valid); end
    step();
    req_valid = '0;
    resp_ready = '0;
    @(negedge i_clk);
    total++; if (rom_addr !== a1) begin bad++; $display("FAIL stall_next_addr got=%h exp=%h", rom_addr, a1); end
    step();
    resp_ready = 3'b010;
    @(negedge i_clk);
    total++; if (resp_valid !== 3'b010) begin bad++; $display("FAIL stall_next_valid got=%b exp=010", resp_valid); end
    total++; if (resp_data !== rom_f(a1)) begin bad++; $display("FAIL stall_next_data got=%h exp=%h", resp_data, rom_f(a1)); end
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    set_addr(2, 12'h222);
    set_addr(1, 12'h111);
    req_valid = 3'b100;
    resp_ready = '1;
    @(negedge i_clk);
    total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL wrap_first got=%b exp=100", req_ready); end
    step();
    req_valid = '0;
    step();
    step();
    req_valid = 3'b110;
    @(negedge i_clk);
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL wrap_grant got=%b exp=010", req_ready); end
    step();
    req_valid = '0;
    step();
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_addr(0, 12'h0AB);
    req_valid = 3'b001;
    step();
    req_valid = '0;
    step();
    @(negedge i_clk);
    total++; if (resp_valid !== 3'b001) begin bad++; $display("FAIL arst_pre_valid got=%b exp=001", resp_valid); end
    #1;
    i_nrst = 1'b0;
    req_valid = '1;
    set_addr(0, 12'h3C5);
    #1;
    total++; if (resp_valid !== 3'b000) begin bad++; $display("FAIL arst_valid got=%b exp=000", resp_valid); end
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL arst_ready got=%b exp=000", req_ready); end
    total++; if (rom_addr !== 12'h000) begin bad++; $display("FAIL arst_rom_addr got=%h exp=000", rom_addr); end
    total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL arst_data got=%h exp=0", resp_data); end
    @(posedge i_clk);
    #1;
    i_nrst = 1'b1;
    resp_ready = '1;
    @(negedge i_clk);
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL arst_first_grant got=%b exp=001", req_ready); end
    step();
    req_valid = '0;
    step();
    @(negedge i_clk);
    total++; if (resp_valid !== 3'b001) begin bad++; $display("FAIL arst_new_valid got=%b exp=001", resp_valid); end
    total++; if (resp_data !== rom_f(12'h3C5)) begin bad++; $display("FAIL arst_new_data got=%h exp=%h", resp_data, rom_f(12'h3C5)); end
    step();
  endtask

  task automatic test_stats();
    logic [NR*32-1:0] exp;
    do_reset();
    for (int i = 0; i < 7; i++) serve(1);
    for (int i = 0; i < 2; i++) serve(0);
`ifdef ROM_ARB_STAT_EN
    exp = {32'd0, 32'd7, 32'd2};
`else
    exp = '0;
`endif
    @(negedge i_clk);
    total++; if (stat_cnt !== exp) begin bad++; $display("FAIL stats got=%h exp=%h", stat_cnt, exp); end
    step();
  endtask

  // Random traffic against a transaction-level model of the arbiter.
  task automatic test_random();
    int            phase;   // 0 free, 1 ROM read pending, 2 response offered
    int            owner, last, g;
    logic [AB-1:0] m_addr;
    logic [31:0]   m_cnt [NR];
    logic [NR-1:0] e_ready, e_rv;
    logic [31:0]   e_data;
    logic [NR*32-1:0] e_stat;
    do_reset();
    phase = 0; owner = 0; last = int'(NR) - 1; m_addr = '0;
    for (int k = 0; k < int'(NR); k++) m_cnt[k] = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid  = NR'($urandom);
      req_addr   = (NR*AB)'({$urandom, $urandom});
      resp_ready = NR'($urandom);
      @(negedge i_clk);
      e_rv   = (phase == 2) ? oh(owner) : '0;
      e_data = (phase == 2) ? rom_f(m_addr) : 32'h0;
      g = -1;
      if (phase == 0 || (phase == 2 && resp_ready[owner])) g = next_owner(req_valid, last);
      e_ready = oh(g);
      total++; if (req_ready !== e_ready) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end
      total++; if (resp_valid !== e_rv) begin bad++; $display("FAIL rand_resp_valid cyc=%0d got=%b exp=%b", cyc, resp_valid, e_rv); end
      total++; if (resp_data !== e_data) begin bad++; $display("FAIL rand_resp_data cyc=%0d got=%h exp=%h", cyc, resp_data, e_data); end
      total++; if (rom_addr !== m_addr) begin bad++; $display("FAIL rand_rom_addr cyc=%0d got=%h exp=%h", cyc, rom_addr, m_addr); end
      if (g >= 0) begin
        m_addr = req_addr[g*AB +: AB];
        owner = g;
        last = g;
        m_cnt[g] = m_cnt[g] + 32'd1;
        phase = 1;
      end else if (phase == 1) begin
        phase = 2;
      end else if (phase == 2 && resp_ready[owner]) begin
        phase = 0;
      end
      step();
    end
    req_valid = '0;
`ifdef ROM_ARB_STAT_EN
    for (int k = 0; k < int'(NR); k++) e_stat[k*32 +: 32] = m_cnt[k];
`else
    e_stat = '0;
`endif
    @(negedge i_clk);
    total++; if (stat_cnt !== e_stat) begin bad++; $display("FAIL rand_stats got=%h exp=%h", stat_cnt, e_stat); end
    step();
  endtask

  initial begin
    i_clk = 1'b0;
    i_nrst = 1'b0;
    req_valid = '0;
    req_addr = '0;
    resp_ready = '0;
    #3;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_async_reset();
    test_stats();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rom_rr_arbiter
